// File: rtl/decoder_pkg.sv
// Shared widths and the one-hot helper for the 3-to-8 select/strobe decoder.
package decoder_pkg;

  localparam int SEL_W = 3;
  localparam int OUT_W = 8;

  // A case table keeps the result to at most one active bit for any 0/1 select.
  function automatic logic [OUT_W-1:0] onehot3to8(input logic [SEL_W-1:0] sel);
    logic [OUT_W-1:0] res;
    res = '0;
    case (sel)
      3'd0:    res = 8'h01;
      3'd1:    res = 8'h02;
      3'd2:    res = 8'h04;
      3'd3:    res = 8'h08;
      3'd4:    res = 8'h10;
      3'd5:    res = 8'h20;
      3'd6:    res = 8'h40;
      3'd7:    res = 8'h80;
      default: res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/decoder_3to8_core.sv
// Purely combinational active-high 3-to-8 one-hot decode.
module decoder_3to8_core
  import decoder_pkg::*;
(
  input  logic [SEL_W-1:0] sel_i,
  output logic [OUT_W-1:0] onehot_o
);

  assign onehot_o = onehot3to8(sel_i);

endmodule

// File: rtl/decoder_3to8.sv
// Registered 3-to-8 decoder: enable gating, optional active-low polarity and
// optional output register around the combinational core.
module decoder_3to8
  import decoder_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b0,
  parameter bit REG_OUT    = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             x,
  input  logic             y,
  input  logic             z,
  input  logic             en,
  output logic [OUT_W-1:0] d,
  output logic             valid
);

  localparam logic [OUT_W-1:0] IDLE = ACTIVE_LOW ? {OUT_W{1'b1}} : {OUT_W{1'b0}};

  logic [OUT_W-1:0] onehot;
  logic [OUT_W-1:0] d_d;
  logic             valid_d;

  decoder_3to8_core u_core (
    .sel_i    ({x, y, z}),
    .onehot_o (onehot)
  );

  always_comb begin
    d_d     = IDLE;
    valid_d = 1'b0;
    if (en) begin
      d_d     = ACTIVE_LOW ? ~onehot : onehot;
      valid_d = 1'b1;
    end
  end

  generate
    if (REG_OUT) begin : g_reg
      logic [OUT_W-1:0] d_q;
      logic             valid_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          d_q     <= IDLE;
          valid_q <= 1'b0;
        end else begin
          d_q     <= d_d;
          valid_q <= valid_d;
        end
      end

      assign d     = d_q;
      assign valid = valid_q;
    end else begin : g_comb
      // Clock and reset have no function when the output is combinational.
      logic unused_clk_rst;
      assign unused_clk_rst = &{1'b0, clk, rst_n};

      assign d     = d_d;
      assign valid = valid_d;
    end
  endgenerate

endmodule

// File: tb/tb_decoder_3to8.sv
// Self-checking bench for decoder_3to8 in registered active-high, registered
// active-low and combinational configurations.
module tb_decoder_3to8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       x, y, z, en;
  logic [7:0] d_hi, d_lo, d_cmb;
  logic       v_hi, v_lo, v_cmb;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  decoder_3to8 #(.ACTIVE_LOW(1'b0), .REG_OUT(1'b1)) u_hi (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y), .z(z), .en(en), .d(d_hi), .valid(v_hi));

  decoder_3to8 #(.ACTIVE_LOW(1'b1), .REG_OUT(1'b1)) u_lo (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y), .z(z), .en(en), .d(d_lo), .valid(v_lo));

  decoder_3to8 #(.ACTIVE_LOW(1'b0), .REG_OUT(1'b0)) u_cmb (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y), .z(z), .en(en), .d(d_cmb), .valid(v_cmb));

  typedef struct {
    logic [2:0] sel;
    logic       en;
    logic [7:0] exp_hi;
    logic [7:0] exp_lo;
    logic       exp_v;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    else
      passed++;
  endtask

  // One-hot invariant on every cycle, sampled away from the active edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1 || rst_n === 1'b0) begin
      check("onehot_hi", 8'($countones(d_hi)), {7'd0, v_hi});
      check("onehot_lo", 8'($countones(~d_lo)), {7'd0, v_lo});
    end
  end

  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    {x, y, z} = v.sel;
    en        = v.en;
    #1;
    check($sformatf("cmb_d[%0d]", idx), d_cmb, v.exp_hi);
    check($sformatf("cmb_v[%0d]", idx), {7'd0, v_cmb}, {7'd0, v.exp_v});
    @(posedge clk);
    #1;
    check($sformatf("hi_d[%0d]", idx), d_hi, v.exp_hi);
    check($sformatf("hi_v[%0d]", idx), {7'd0, v_hi}, {7'd0, v.exp_v});
    check($sformatf("lo_d[%0d]", idx), d_lo, v.exp_lo);
    check($sformatf("lo_v[%0d]", idx), {7'd0, v_lo}, {7'd0, v.exp_v});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{3'b000, 1'b1, 8'h01, 8'hFE, 1'b1};
    vecs[1]  = '{3'b001, 1'b1, 8'h02, 8'hFD, 1'b1};
    vecs[2]  = '{3'b010, 1'b1, 8'h04, 8'hFB, 1'b1};
    vecs[3]  = '{3'b011, 1'b1, 8'h08, 8'hF7, 1'b1};
    vecs[4]  = '{3'b100, 1'b1, 8'h10, 8'hEF, 1'b1};
    vecs[5]  = '{3'b101, 1'b1, 8'h20, 8'hDF, 1'b1};
    vecs[6]  = '{3'b110, 1'b1, 8'h40, 8'hBF, 1'b1};
    vecs[7]  = '{3'b111, 1'b1, 8'h80, 8'h7F, 1'b1};
    vecs[8]  = '{3'b101, 1'b1, 8'h20, 8'hDF, 1'b1};
    vecs[9]  = '{3'b101, 1'b0, 8'h00, 8'hFF, 1'b0};
    vecs[10] = '{3'b101, 1'b1, 8'h20, 8'hDF, 1'b1};
    vecs[11] = '{3'b011, 1'b1, 8'h08, 8'hF7, 1'b1};
    vecs[12] = '{3'b011, 1'b0, 8'h00, 8'hFF, 1'b0};

    // Reset held with a live select: outputs stay idle across clock edges.
    rst_n = 1'b0;
    en    = 1'b1;
    {x, y, z} = 3'b111;
    #2;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_hi_d", d_hi, 8'h00);
    check("rst_hi_v", {7'd0, v_hi}, 8'h00);
    check("rst_lo_d", d_lo, 8'hFF);
    check("rst_lo_v", {7'd0, v_lo}, 8'h00);
    check("rst_cmb_d", d_cmb, 8'h80);

    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel_hold_hi_d", d_hi, 8'h00);
    @(posedge clk);
    #1;
    check("rel_hi_d", d_hi, 8'h80);
    check("rel_hi_v", {7'd0, v_hi}, 8'h01);
    check("rel_lo_d", d_lo, 8'h7F);

    for (int i = 0; i < 13; i++)
      apply(vecs[i], i);

    // Combinational select change between edges; registered output must hold.
    @(negedge clk);
    en = 1'b1;
    {x, y, z} = 3'b000;
    #1;
    check("cmb_000", d_cmb, 8'h01);
    check("cmb_hold_hi", d_hi, 8'h00);
    {x, y, z} = 3'b110;
    #1;
    check("cmb_110", d_cmb, 8'h40);
    check("cmb_hold_hi2", d_hi, 8'h00);
    check("cmb_hold_lo", d_lo, 8'hFF);

    // Asynchronous reset between edges while d=08.
    apply('{3'b011, 1'b1, 8'h08, 8'hF7, 1'b1}, 100);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_hi_d", d_hi, 8'h00);
    check("arst_hi_v", {7'd0, v_hi}, 8'h00);
    check("arst_lo_d", d_lo, 8'hFF);
    check("arst_lo_v", {7'd0, v_lo}, 8'h00);
    @(posedge clk);
    #1;
    check("arst_edge_hi_d", d_hi, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("arst_rel_hi_d", d_hi, 8'h08);
    check("arst_rel_lo_d", d_lo, 8'hF7);
    check("arst_rel_hi_v", {7'd0, v_hi}, 8'h01);

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
